regfile_wb_arbiter: RTL

- Shares the register file's single write port (A3/WD3/WE3) between two requesters:
  - the primary single-cycle writeback path;
  - a long-latency unit (load/mul-div) that retires through a small buffer.
- Holds a per-register busy scoreboard so decode can detect RAW/WAW hazards against in-flight long-latency results.
- Sits between writeback and the register file, one instance per core.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_retire_fifo.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
// The register count, index width, arbiter states and retire-buffer entry live here.
package rf_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      wd;
    } wb_entry;

endpackage

// File: rtl/rf_retire_fifo.sv
// Small retire buffer for long-latency results: a power-of-2 FIFO of {rd, wd}.
// A push while full is dropped, and a pop while empty is ignored.
module rf_retire_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_entry push_data,
    input  logic    pop,
    output wb_entry head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between primary writeback and a buffered
// long-latency requester, and tracks per-register busy bits for decode hazards.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned MAX_WAIT     = 4,
    parameter int unsigned Data_width   = 32,
    parameter int unsigned Adress_width = 5
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    p_we,
    input  logic [Adress_width-1:0] p_rd,
    input  logic [Data_width-1:0]   p_wd,
    output logic                    p_stall,
    input  logic                    l_valid,
    input  logic [Adress_width-1:0] l_rd,
    input  logic [Data_width-1:0]   l_wd,
    output logic                    l_ready,
    input  logic                    iss_valid,
    input  logic [Adress_width-1:0] iss_rd,
    input  logic [Adress_width-1:0] q_rs1,
    input  logic [Adress_width-1:0] q_rs2,
    input  logic [Adress_width-1:0] q_rd,
    output logic                    hz_rs1,
    output logic                    hz_rs2,
    output logic                    hz_rd,
    output logic [Adress_width-1:0] A3,
    output logic [Data_width-1:0]   WD3,
    output logic                    WE3
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

    arb_state_e            state, state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_inc;
    logic [REG_COUNT-1:0]  busy, busy_next;
    wb_entry               l_entry;
    wb_entry               head;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  blocked;
    logic                  grant;
    logic [REG_IDX_W-1:0]  grant_rd;
    logic [XLEN-1:0]       grant_wd;

    assign l_entry = '{rd: l_rd, wd: l_wd};

    rf_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (reset),
        .push      (l_valid),
        .push_data (l_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign l_ready  = !full;
    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;

    // FORCE is entered on the blocked cycle in which the count reaches MAX_WAIT-1,
    // so a head is passed over at most MAX_WAIT-1 times before it takes the port.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_rd   = '0;
        grant_wd   = '0;
        pop        = 1'b0;
        blocked    = 1'b0;
        p_stall    = 1'b0;
        if (!reset) begin
            unique case (state)
                NORMAL: begin
                    if (p_we) begin
                        grant    = 1'b1;
                        grant_rd = p_rd;
                        grant_wd = p_wd;
                        blocked  = !empty;
                    end else if (!empty) begin
                        grant    = 1'b1;
                        grant_rd = head.rd;
                        grant_wd = head.wd;
                        pop      = 1'b1;
                    end
                    if (blocked && wait_inc == WAIT_MAX) state_next = FORCE;
                end
                FORCE: begin
                    if (!empty) begin
                        grant    = 1'b1;
                        grant_rd = head.rd;
                        grant_wd = head.wd;
                        pop      = 1'b1;
                        p_stall  = p_we;
                    end
                    state_next = NORMAL;
                end
            endcase
        end
    end

    assign WE3 = grant && (grant_rd != '0);
    assign A3  = grant_rd;
    assign WD3 = grant_wd;

    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.rd] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            busy     <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            if (pop || empty)  wait_cnt <= '0;
            else if (blocked)  wait_cnt <= wait_inc;
        end
    end

    assign hz_rs1 = busy[q_rs1];
    assign hz_rs2 = busy[q_rs2];
    assign hz_rd  = busy[q_rd];

endmodule
